// File: rtl/partition_ctrl_pkg.sv
// Shared definitions for the partition sequencer: default widths/latencies
// (also used by the swap unit) and the sequencer state encoding.
package partition_ctrl_pkg;

    localparam int WORD_SIZE_DEF = 16;
    localparam int SWAP_LAT_DEF  = 5;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_RD_PIV = 4'd1,
        ST_LD_PIV = 4'd2,
        ST_RD_J   = 4'd3,
        ST_CMP    = 4'd4,
        ST_SWAP   = 4'd5,
        ST_WAIT   = 4'd6,
        ST_FIN    = 4'd7,
        ST_FSWAP  = 4'd8,
        ST_FWAIT  = 4'd9,
        ST_DONE   = 4'd10
    } state_e;

    // States in which the swap unit owns the register-file port.
    function automatic logic swap_owns_port(input state_e s);
        return (s == ST_SWAP) || (s == ST_WAIT) || (s == ST_FSWAP) || (s == ST_FWAIT);
    endfunction

    function automatic logic is_swap_pulse(input state_e s);
        return (s == ST_SWAP) || (s == ST_FSWAP);
    endfunction

endpackage

// File: rtl/partition_ctrl_swap_wait_timer.sv
// Hold-off timer for an issued swap: loaded on the swap_en cycle, expires on
// the last of LAT following cycles.
module partition_ctrl_swap_wait_timer #(
    parameter int LAT   = 5,
    parameter int CNT_W = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expire
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CNT_W'(LAT);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/partition_ctrl.sv
// Lomuto partition sequencer: reads pivot A[hi], scans j=lo..hi-1, issues swap
// requests to the swap unit and reports the final pivot index.
module partition_ctrl
    import partition_ctrl_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int SWAP_LAT  = SWAP_LAT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WORD_SIZE-1:0] lo,
    input  logic [WORD_SIZE-1:0] hi,
    output logic [WORD_SIZE-1:0] reg_addr,
    output logic                 reg_READ_EN,
    input  logic [WORD_SIZE-1:0] reg_out,
    output logic                 swap_en,
    output logic [WORD_SIZE-1:0] addr1,
    output logic [WORD_SIZE-1:0] addr2,
    output logic                 swap_active,
    output logic                 busy,
    output logic                 done,
    output logic [WORD_SIZE-1:0] pivot_idx,
    output logic                 bad_range,
    output logic [WORD_SIZE-1:0] swap_count
);

    localparam int TMR_W = (SWAP_LAT < 1) ? 1 : $clog2(SWAP_LAT + 1);

    state_e state_q, state_d;

    logic [WORD_SIZE-1:0] lo_q, lo_d;
    logic [WORD_SIZE-1:0] hi_q, hi_d;
    logic [WORD_SIZE-1:0] i_q, i_d;
    logic [WORD_SIZE-1:0] j_q, j_d;
    logic [WORD_SIZE-1:0] piv_q, piv_d;
    logic [WORD_SIZE-1:0] addr1_q, addr1_d;
    logic [WORD_SIZE-1:0] addr2_q, addr2_d;
    logic [WORD_SIZE-1:0] pidx_q, pidx_d;
    logic [WORD_SIZE-1:0] cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 bad_q, bad_d;

    logic                 tmr_load;
    logic                 tmr_expire;
    logic [WORD_SIZE-1:0] i_inc;
    logic [WORD_SIZE-1:0] j_inc;
    logic                 j_last;
    logic                 less;

    assign i_inc  = i_q + WORD_SIZE'(1);
    assign j_inc  = j_q + WORD_SIZE'(1);
    assign j_last = (j_inc == hi_q);
    assign less   = (reg_out < piv_q);

    assign tmr_load = is_swap_pulse(state_q);

    partition_ctrl_swap_wait_timer #(
        .LAT   (SWAP_LAT),
        .CNT_W (TMR_W)
    ) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (tmr_load),
        .expire (tmr_expire)
    );

    always_comb begin
        state_d     = state_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        i_d         = i_q;
        j_d         = j_q;
        piv_d       = piv_q;
        addr1_d     = addr1_q;
        addr2_d     = addr2_q;
        pidx_d      = pidx_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        bad_d       = bad_q;
        reg_addr    = '0;
        reg_READ_EN = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    lo_d    = lo;
                    hi_d    = hi;
                    i_d     = lo;
                    j_d     = lo;
                    cnt_d   = '0;
                    bad_d   = 1'b0;
                    busy_d  = 1'b1;
                    // Empty or single-element range: nothing to read, pivot stays at lo.
                    state_d = (lo >= hi) ? ST_DONE : ST_RD_PIV;
                end
            end
            ST_RD_PIV: begin
                reg_addr    = hi_q;
                reg_READ_EN = 1'b1;
                state_d     = ST_LD_PIV;
            end
            ST_LD_PIV: begin
                piv_d   = reg_out;
                state_d = ST_RD_J;
            end
            ST_RD_J: begin
                reg_addr    = j_q;
                reg_READ_EN = 1'b1;
                state_d     = ST_CMP;
            end
            ST_CMP: begin
                if (less && (i_q != j_q)) begin
                    addr1_d = i_q;
                    addr2_d = j_q;
                    state_d = ST_SWAP;
                end else begin
                    if (less) begin
                        i_d = i_inc;
                    end
                    j_d     = j_inc;
                    state_d = j_last ? ST_FIN : ST_RD_J;
                end
            end
            ST_SWAP: begin
                cnt_d   = cnt_q + WORD_SIZE'(1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // i/j advance only once the swap unit has released the port.
                if (tmr_expire) begin
                    i_d     = i_inc;
                    j_d     = j_inc;
                    state_d = j_last ? ST_FIN : ST_RD_J;
                end
            end
            ST_FIN: begin
                if (i_q != hi_q) begin
                    addr1_d = i_q;
                    addr2_d = hi_q;
                    state_d = ST_FSWAP;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_FSWAP: begin
                cnt_d   = cnt_q + WORD_SIZE'(1);
                state_d = ST_FWAIT;
            end
            ST_FWAIT: begin
                if (tmr_expire) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                pidx_d  = i_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                bad_d   = (lo_q > hi_q);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            lo_q    <= '0;
            hi_q    <= '0;
            i_q     <= '0;
            j_q     <= '0;
            piv_q   <= '0;
            addr1_q <= '0;
            addr2_q <= '0;
            pidx_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            i_q     <= i_d;
            j_q     <= j_d;
            piv_q   <= piv_d;
            addr1_q <= addr1_d;
            addr2_q <= addr2_d;
            pidx_q  <= pidx_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bad_q   <= bad_d;
        end
    end

    // Swap handshake decoded straight from state so a reset drops it on the next edge.
    assign swap_en     = is_swap_pulse(state_q);
    assign swap_active = swap_owns_port(state_q);
    assign addr1       = addr1_q;
    assign addr2       = addr2_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pivot_idx   = pidx_q;
    assign bad_range   = bad_q;
    assign swap_count  = cnt_q;

endmodule

// File: tb/tb_partition_ctrl.sv
// Bench for partition_ctrl: register file + instant swap unit around the DUT,
// a reference Lomuto partition model, and a per-cycle protocol checker.
module tb_partition_ctrl;

    localparam int W   = 16;
    localparam int LAT = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] lo, hi;
    logic [W-1:0] reg_addr, reg_out, addr1, addr2, pivot_idx, swap_count;
    logic         reg_READ_EN, swap_en, swap_active, busy, done, bad_range;

    always #5 clk = ~clk;

    partition_ctrl #(.WORD_SIZE(W), .SWAP_LAT(LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .lo          (lo),
        .hi          (hi),
        .reg_addr    (reg_addr),
        .reg_READ_EN (reg_READ_EN),
        .reg_out     (reg_out),
        .swap_en     (swap_en),
        .addr1       (addr1),
        .addr2       (addr2),
        .swap_active (swap_active),
        .busy        (busy),
        .done        (done),
        .pivot_idx   (pivot_idx),
        .bad_range   (bad_range),
        .swap_count  (swap_count)
    );

    // Register file with 1-cycle read latency; swap unit modelled as completing at once.
    logic [W-1:0] mem [16];
    logic [W-1:0] load_data [16];
    logic         load_en = 1'b0;

    always @(posedge clk) begin
        if (load_en) begin
            mem <= load_data;
        end else if (swap_en) begin
            mem[addr1[3:0]] <= mem[addr2[3:0]];
            mem[addr2[3:0]] <= mem[addr1[3:0]];
        end
        if (rst) reg_out <= '0;
        else if (reg_READ_EN) reg_out <= mem[reg_addr[3:0]];
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: plain Lomuto partition over an array copy.
    logic [W-1:0] model_mem [16];
    logic [31:0]  exp_pairs [$];
    int           exp_pivot, exp_count, exp_lat, exp_bad, exp_reads;

    task automatic model_run(input int lo_v, input int hi_v);
        int i;
        logic [W-1:0] piv, t;
        exp_pairs.delete();
        exp_count = 0;
        exp_bad   = (lo_v > hi_v);
        exp_reads = (lo_v < hi_v);
        if (lo_v >= hi_v) begin
            exp_pivot = lo_v;
            exp_lat   = 1;
            return;
        end
        piv     = model_mem[hi_v];
        i       = lo_v;
        exp_lat = 2;
        for (int j = lo_v; j < hi_v; j++) begin
            if (model_mem[j] < piv) begin
                if (i != j) begin
                    exp_pairs.push_back({16'(i), 16'(j)});
                    t = model_mem[i]; model_mem[i] = model_mem[j]; model_mem[j] = t;
                    exp_count++;
                    exp_lat += 3 + LAT;
                end else begin
                    exp_lat += 2;
                end
                i++;
            end else begin
                exp_lat += 2;
            end
        end
        exp_lat += 1;
        if (i != hi_v) begin
            exp_pairs.push_back({16'(i), 16'(hi_v)});
            t = model_mem[i]; model_mem[i] = model_mem[hi_v]; model_mem[hi_v] = t;
            exp_count++;
            exp_lat += 1 + LAT;
        end
        exp_lat += 1;
        exp_pivot = i;
    endtask

    // Per-cycle protocol checks and swap-request scoreboard.
    logic chk_en       = 1'b0;
    logic prev_swap_en = 1'b0;
    int   rd_seen      = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("port_exclusive", {31'b0, swap_active & reg_READ_EN}, 0);
            check("swap_en_single", {31'b0, swap_en & prev_swap_en}, 0);
            check("swap_en_active", {31'b0, swap_en & ~swap_active}, 0);
            check("done_not_busy", {31'b0, done & busy}, 0);
            if (reg_READ_EN) rd_seen++;
            if (swap_en) begin
                check("swap_expected", {31'b0, exp_pairs.size() > 0}, 1);
                if (exp_pairs.size() > 0) check("swap_pair", {addr1, addr2}, exp_pairs.pop_front());
            end
        end
        prev_swap_en = swap_en;
    end

    task automatic load_array();
        @(posedge clk); #1 load_en = 1'b1;
        @(posedge clk); #1 load_en = 1'b0;
        for (int k = 0; k < 16; k++) model_mem[k] = load_data[k];
    endtask

    task automatic set_data(input logic [W-1:0] a0, a1, a2, a3, a4, a5, a6, a7);
        for (int k = 0; k < 16; k++) load_data[k] = W'(100 + k);
        load_data[0] = a0; load_data[1] = a1; load_data[2] = a2; load_data[3] = a3;
        load_data[4] = a4; load_data[5] = a5; load_data[6] = a6; load_data[7] = a7;
    endtask

    int last_lat;

    task automatic run_case(input string name, input int lo_v, input int hi_v, input bit poke);
        int n;
        bit got;
        int mism;
        load_array();
        model_run(lo_v, hi_v);
        rd_seen = 0;
        start = 1'b1; lo = W'(lo_v); hi = W'(hi_v);
        @(posedge clk); #1 start = 1'b0;
        n = 0; got = 0;
        while (!got && n < 2000) begin
            if (poke && n == 3) begin
                start = 1'b1; lo = W'(0); hi = W'(1);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); n++; #1;
            if (done) got = 1;
        end
        start = 1'b0;
        last_lat = n;
        check({name, " done_seen"}, {31'b0, got}, 1);
        check({name, " latency"}, n, exp_lat);
        check({name, " pivot_idx"}, pivot_idx, exp_pivot);
        check({name, " swap_count"}, swap_count, exp_count);
        check({name, " bad_range"}, {31'b0, bad_range}, exp_bad);
        check({name, " swaps_left"}, exp_pairs.size(), 0);
        check({name, " reads_seen"}, {31'b0, rd_seen > 0}, exp_reads);
        mism = 0;
        for (int k = 0; k < 16; k++) if (mem[k] !== model_mem[k]) mism++;
        check({name, " mem_mismatches"}, mism, 0);
        @(posedge clk); #1;
        check({name, " done_one_cycle"}, {31'b0, done}, 0);
        check({name, " pivot_held"}, pivot_idx, exp_pivot);
        $display("[TB] %s lo=%0d hi=%0d pivot=%0d swaps=%0d bad=%0d cycles=%0d",
                 name, lo_v, hi_v, pivot_idx, swap_count, bad_range, last_lat);
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; lo = '0; hi = '0;
        for (int k = 0; k < 16; k++) load_data[k] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", {31'b0, busy}, 0);
        check("reset done", {31'b0, done}, 0);
        check("reset swap_en", {31'b0, swap_en}, 0);
        check("reset swap_active", {31'b0, swap_active}, 0);
        check("reset reg_READ_EN", {31'b0, reg_READ_EN}, 0);
        check("reset pivot_idx", pivot_idx, 0);
        check("reset swap_count", swap_count, 0);
        check("reset bad_range", {31'b0, bad_range}, 0);
        rst = 1'b0;
        chk_en = 1'b1;

        set_data(3, 1, 2, 0, 0, 0, 0, 0);
        run_case("abc312", 0, 2, 1'b0);
        check("abc312 lit pivot", pivot_idx, 1);
        check("abc312 lit count", swap_count, 2);
        check("abc312 lit sorted", {mem[0][7:0], mem[1][7:0], mem[2][7:0], 8'h0}, 32'h01020300);

        set_data(1, 2, 3, 4, 0, 0, 0, 0);
        run_case("ascending", 0, 3, 1'b0);
        check("ascending lit pivot", pivot_idx, 3);
        check("ascending lit count", swap_count, 0);
        check("ascending lit cycles", last_lat, 10);

        set_data(2, 2, 2, 0, 0, 0, 0, 0);
        run_case("equal", 0, 2, 1'b0);
        check("equal lit pivot", pivot_idx, 0);
        check("equal lit count", swap_count, 1);

        set_data(7, 7, 7, 7, 7, 7, 7, 7);
        run_case("single", 5, 5, 1'b0);
        check("single lit pivot", pivot_idx, 5);
        check("single lit cycles", last_lat, 1);

        run_case("inverted", 6, 2, 1'b0);
        check("inverted lit bad", {31'b0, bad_range}, 1);
        check("inverted lit pivot", pivot_idx, 6);

        set_data(5, 9, 1, 7, 3, 8, 2, 6);
        run_case("mixed_poke", 0, 7, 1'b1);

        set_data(9, 8, 7, 1, 4, 2, 6, 5);
        run_case("subrange", 2, 6, 1'b0);

        // Reset while the first swap of a partition is in its hold-off.
        set_data(3, 1, 2, 0, 0, 0, 0, 0);
        load_array();
        model_run(0, 2);
        start = 1'b1; lo = 0; hi = 2;
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        while (!(swap_active && !swap_en) && n < 200) begin
            @(posedge clk); n++; #1;
        end
        check("rst_mid reached_wait", {31'b0, swap_active & ~swap_en}, 1);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check("rst_mid busy", {31'b0, busy}, 0);
        check("rst_mid swap_en", {31'b0, swap_en}, 0);
        check("rst_mid swap_active", {31'b0, swap_active}, 0);
        check("rst_mid done", {31'b0, done}, 0);
        exp_pairs.delete();
        $display("[TB] rst_mid busy=%0d swap_en=%0d swap_active=%0d", busy, swap_en, swap_active);

        set_data(3, 1, 2, 0, 0, 0, 0, 0);
        run_case("after_rst", 0, 2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

endmodule
